fetch_arbiter: RTL and testbench

FETCH_ARBITER -- requirements
Module: fetch_arbiter

---
 rtl/fetch_arbiter.sv | 159 +++++++++++++++
 tb/tb_fetch_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_arbiter.sv
// fetch_arbiter: shares one program-memory read channel among NUM_REQUESTERS
// fetchers. One memory transaction is outstanding at a time; the grant is
// round-robin by default, or fixed lowest-index-first when the build macro
// FETCH_ARB_FIXED_PRIO_EN is defined.
//
// Handshake contract (both sides):
//   A fetcher raises req_read_valid[i] with its address. Once granted, the
//   address is captured and later changes are ignored. When memory answers,
//   req_read_ready[i] rises with the instruction on slice i and stays high
//   while req_read_valid[i] stays high; the fetcher ends the transaction by
//   dropping valid, and ready falls on the next edge. On the memory side,
//   mem_read_valid/mem_read_address hold until a cycle with mem_read_ready=1;
//   mem_read_ready seen in any other state is ignored.
//
// dbg_state and dbg_rr_ptr expose the FSM state and round-robin pointer.
module fetch_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ADDRESS_BITS   = 8,
  parameter int DATA_BITS      = 16,
  localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQUESTERS-1:0]            req_read_valid,
  input  logic [NUM_REQUESTERS*ADDRESS_BITS-1:0] req_read_address,
  output logic [NUM_REQUESTERS-1:0]            req_read_ready,
  output logic [NUM_REQUESTERS*DATA_BITS-1:0]  req_read_data,
  output logic                                 mem_read_valid,
  output logic [ADDRESS_BITS-1:0]              mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic [1:0]                           dbg_state,
  output logic [PTR_W-1:0]                     dbg_rr_ptr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAITING  = 2'd1,
    RELAYING = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [PTR_W-1:0]          g_q, g_d;
  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      mem_valid_q, mem_valid_d;
  logic [ADDRESS_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [NUM_REQUESTERS-1:0] ready_q, ready_d;
  logic [DATA_BITS-1:0]      data_q [NUM_REQUESTERS];
  logic [DATA_BITS-1:0]      data_d [NUM_REQUESTERS];

  logic [ADDRESS_BITS-1:0]   addr_arr [NUM_REQUESTERS];
  logic [PTR_W-1:0]          search_start;
  logic [PTR_W-1:0]          idx;
  logic [PTR_W-1:0]          pick;
  logic                      hit;
  logic [PTR_W-1:0]          next_ptr;

  // Unpack request addresses and pack returned data slices.
  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_slices
    assign addr_arr[i] = req_read_address[i*ADDRESS_BITS +: ADDRESS_BITS];
    assign req_read_data[i*DATA_BITS +: DATA_BITS] = data_q[i];
  end

  assign req_read_ready   = ready_q;
  assign mem_read_valid   = mem_valid_q;
  assign mem_read_address = mem_addr_q;
  assign dbg_state        = state_q;
  assign dbg_rr_ptr       = rr_ptr_q;

`ifdef FETCH_ARB_FIXED_PRIO_EN
  // Fixed priority: search always begins at requester 0.
  assign search_start = '0;
  assign next_ptr     = '0;
`else
  // Round-robin: search begins at the pointer, which moves past the last grant.
  assign search_start = rr_ptr_q;
  assign next_ptr     = PTR_W'((int'(g_q) + 1) % NUM_REQUESTERS);
`endif

  // Find the first valid requester starting at search_start, wrapping around.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    idx  = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      idx = PTR_W'((int'(search_start) + k) % NUM_REQUESTERS);
      if (!hit && req_read_valid[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  // Next-state and output logic of the grant / wait / relay FSM.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_ptr_d    = rr_ptr_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    ready_d     = ready_q;
    data_d      = data_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          g_d         = pick;
          mem_valid_d = 1'b1;
          mem_addr_d  = addr_arr[pick];
          state_d     = WAITING;
        end
      end
      WAITING: begin
        if (mem_read_ready) begin
          data_d[g_q]  = mem_read_data;
          ready_d[g_q] = 1'b1;
          mem_valid_d  = 1'b0;
          state_d      = RELAYING;
        end
      end
      RELAYING: begin
        // Ready is held until the granted fetcher lets go of valid.
        if (!req_read_valid[g_q]) begin
          ready_d[g_q] = 1'b0;
          rr_ptr_d     = next_ptr;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      g_q         <= '0;
      rr_ptr_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      ready_q     <= '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      ready_q     <= ready_d;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_arbiter.sv
// tb_fetch_arbiter: directed scenarios followed by randomized transactions,
// checked against a transaction-level model of the arbiter (pending set,
// grant pointer, last delivered word per requester).
module tb_fetch_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int PW = 2;
  localparam int EW = 8 + AW;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_read_valid;
  logic [N*AW-1:0] req_read_address;
  logic [N-1:0]    req_read_ready;
  logic [N*DW-1:0] req_read_data;
  logic            mem_read_valid;
  logic [AW-1:0]   mem_read_address;
  logic            mem_read_ready;
  logic [DW-1:0]   mem_read_data;
  logic [1:0]      dbg_state;
  logic [PW-1:0]   dbg_rr_ptr;

  fetch_arbiter #(
    .NUM_REQUESTERS(N),
    .ADDRESS_BITS  (AW),
    .DATA_BITS     (DW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_read_valid   (req_read_valid),
    .req_read_address (req_read_address),
    .req_read_ready   (req_read_ready),
    .req_read_data    (req_read_data),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .dbg_state        (dbg_state),
    .dbg_rr_ptr       (dbg_rr_ptr)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters and reference model state
  int            vectors = 0;
  int            miscompares = 0;
  bit            pending [N];
  logic [AW-1:0] paddr [N];
  logic [DW-1:0] last_data [N];
  int            ptr;
  logic          exp_mv;
  logic [AW-1:0] exp_maddr;
  logic [N-1:0]  exp_rdy;
  logic [EW-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_read_valid[i] = pending[i];
      req_read_address[i*AW +: AW] = paddr[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      last_data[i] = '0;
    end
    ptr       = 0;
    exp_mv    = 1'b0;
    exp_maddr = '0;
    exp_rdy   = '0;
    exp_q.delete();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mem_valid"}, 64'(mem_read_valid), 64'(exp_mv));
    chk({tag, ".mem_addr"}, 64'(mem_read_address), 64'(exp_maddr));
    chk({tag, ".ready"}, 64'(req_read_ready), 64'(exp_rdy));
    chk({tag, ".rr_ptr"}, 64'(dbg_rr_ptr), 64'(ptr));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s.data%0d", tag, i), 64'(req_read_data[i*DW +: DW]), 64'(last_data[i]));
    end
  endtask

  // Next grant by rule: first pending requester from the pointer, wrapping.
  function automatic int exp_grant();
    int start;
`ifdef FETCH_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < N; k++) begin
      if (pending[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    drive();
    mem_read_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // One full transaction: grant, lat wait cycles, memory answer, hold cycles, release.
  task automatic run_txn(input int lat, input int hold, input bit abort, input bit chaddr,
                         input bit stir, input logic [DW-1:0] data, output logic [N-1:0] rdy_seen);
    int g;
    int gi;
    logic [EW-1:0] rec;
    rdy_seen = '0;
    g = exp_grant();
    if (g < 0) return;
    exp_q.push_back({8'(g), paddr[g]});
    drive();
    tick();
    rec       = exp_q.pop_front();
    gi        = int'(rec[AW +: 8]);
    exp_mv    = 1'b1;
    exp_maddr = rec[AW-1:0];
    check_all("grant");
    if (chaddr) paddr[gi] = AW'($urandom);
    if (abort) pending[gi] = 1'b0;
    if (stir) begin
      for (int i = 0; i < N; i++) begin
        if (i != gi && !pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          paddr[i]   = AW'($urandom);
        end
      end
    end
    drive();
    repeat (lat) begin
      tick();
      check_all("wait");
    end
    mem_read_ready = 1'b1;
    mem_read_data  = data;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data  = DW'($urandom);
    exp_mv        = 1'b0;
    exp_rdy       = '0;
    exp_rdy[gi]   = 1'b1;
    last_data[gi] = data;
    check_all("deliver");
    rdy_seen = req_read_ready;
    if (!abort) begin
      repeat (hold) begin
        if (stir) mem_read_ready = 1'($urandom_range(0, 1));
        mem_read_data = DW'($urandom);
        tick();
        mem_read_ready = 1'b0;
        check_all("hold");
      end
      pending[gi] = 1'b0;
      drive();
    end
    tick();
    exp_rdy = '0;
`ifndef FETCH_ARB_FIXED_PRIO_EN
    ptr = (gi + 1) % N;
`endif
    check_all("release");
  endtask

  logic [N-1:0] rs;
  int           exp_order [4];
  bit           any;

  initial begin
    reset            = 1'b1;
    req_read_valid   = '0;
    req_read_address = '0;
    mem_read_ready   = 1'b0;
    mem_read_data    = '0;
    for (int i = 0; i < N; i++) begin
      pending[i] = 1'b0;
      paddr[i]   = '0;
    end

    // Reset state
    do_reset();
    check_all("reset");
    chk("reset.state", 64'(dbg_state), 64'd0);

    // Spurious memory strobe in IDLE with no requests changes nothing
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    tick();
    mem_read_ready = 1'b0;
    check_all("spurious_idle");

    // Single request: requester 2, address 0x1A, memory answers 3 cycles later
    pending[2] = 1'b1;
    paddr[2]   = 8'h1A;
    run_txn(3, 1, 1'b0, 1'b1, 1'b0, 16'hBEEF, rs);
    chk("single.ready", 64'(rs), 64'(4'b0100));
    chk("single.data2", 64'(req_read_data[2*DW +: DW]), 64'h BEEF);
    chk("single.addr", 64'(mem_read_address), 64'h1A);

    // Contention from reset: all four at once, each releases after its turn
    do_reset();
    for (int i = 0; i < N; i++) begin
      pending[i] = 1'b1;
      paddr[i]   = AW'(8'h10 + i);
    end
    for (int k = 0; k < 4; k++) begin
      run_txn(1, 0, 1'b0, 1'b0, 1'b0, DW'(16'h1000 + k), rs);
      chk($sformatf("contend.grant%0d", k), 64'(rs), 64'(4'b0001 << k));
    end

    // Fairness: requester 0 re-requests at once, requester 3 keeps asking
    do_reset();
`ifdef FETCH_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 3, 0, 3};
`endif
    for (int k = 0; k < 4; k++) begin
      pending[0] = 1'b1;
      paddr[0]   = 8'h20;
      pending[3] = 1'b1;
      paddr[3]   = 8'h23;
      run_txn(0, 0, 1'b0, 1'b0, 1'b0, DW'(16'h2000 + k), rs);
      chk($sformatf("fair.grant%0d", k), 64'(rs), 64'(4'b0001 << exp_order[k]));
    end
    pending[0] = 1'b0;
    pending[3] = 1'b0;
    drive();

    // Abort: requester 1 drops valid while waiting; ready pulses one cycle
    do_reset();
    pending[1] = 1'b1;
    paddr[1]   = 8'h31;
    run_txn(2, 0, 1'b1, 1'b0, 1'b0, 16'h1234, rs);
    chk("abort.ready", 64'(rs), 64'(4'b0010));
    chk("abort.state", 64'(dbg_state), 64'd0);

    // Reset while waiting, then a late memory strobe
    pending[1] = 1'b1;
    paddr[1]   = 8'h55;
    drive();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pending[1] = 1'b0;
    drive();
    model_reset();
    check_all("midreset");
    chk("midreset.state", 64'(dbg_state), 64'd0);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h5A5A;
    tick();
    mem_read_ready = 1'b0;
    check_all("late_strobe");

    // Randomized transactions
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < N; i++) pending[i] = 1'b0;
        drive();
        mem_read_ready = 1'b1;
        mem_read_data  = DW'($urandom);
        tick();
        mem_read_ready = 1'b0;
        check_all("idle_gap");
      end
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1) begin
          pending[i] = 1'b1;
          paddr[i]   = AW'($urandom);
        end
        if (pending[i]) any = 1'b1;
      end
      if (!any) begin
        pending[$urandom_range(0, N-1)] = 1'b1;
      end
      run_txn(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
              ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 1'b1,
              DW'($urandom), rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
